// File: rtl/bg_access_arbiter.sv
// Per-bank-group round-robin arbiter sharing four scratchpad bank groups between
// four LSUs (burst-counted grants) and the external host bus (unbounded hold).
module bg_access_arbiter #(
    parameter int N_LSU = 4,
    parameter int N_BG  = 4,
    parameter int LEN_W = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_LSU-1:0]       lsu_req,
    input  logic [2*N_LSU-1:0]     lsu_bg,
    input  logic [N_LSU-1:0]       lsu_wr,
    input  logic [LEN_W*N_LSU-1:0] lsu_len,
    input  logic [N_BG-1:0]        ex_req,
    output logic [N_LSU-1:0]       lsu_gnt,
    output logic [N_LSU-1:0]       lsu_done,
    output logic [2*N_LSU-1:0]     lsu_w_sel,
    output logic [N_BG-1:0]        bg_busy,
    output logic [2*N_BG-1:0]      bg_owner,
    output logic [N_BG-1:0]        bg_sel,
    output logic [N_BG-1:0]        ex_gnt
);

    typedef enum logic [1:0] {S_IDLE, S_BURST, S_EX} state_t;

    state_t           r_state   [N_BG];
    state_t           w_state_nxt [N_BG];
    logic [1:0]       r_ptr     [N_BG];
    logic [1:0]       w_ptr_nxt [N_BG];
    logic [LEN_W-1:0] r_cnt     [N_BG];
    logic [LEN_W-1:0] w_cnt_nxt [N_BG];
    logic [1:0]       r_own     [N_BG];
    logic [1:0]       w_own_nxt [N_BG];

    logic [N_LSU-1:0]   r_gnt, w_gnt_nxt;
    logic [N_LSU-1:0]   r_done, w_done_nxt;
    logic [2*N_LSU-1:0] r_wsel, w_wsel_nxt;
    logic [N_BG-1:0]    r_busy, w_busy_nxt;
    logic [2*N_BG-1:0]  r_owner, w_owner_nxt;
    logic [N_BG-1:0]    r_sel, w_sel_nxt;
    logic [N_BG-1:0]    r_exg, w_exg_nxt;

    logic [1:0] w_idx;
    logic       w_found;

    // Outputs are registered from the next-state decode so they line up with the state.
    always_comb begin
        w_idx       = '0;
        w_found     = 1'b0;
        w_gnt_nxt   = '0;
        w_done_nxt  = '0;
        w_busy_nxt  = '0;
        w_owner_nxt = '0;
        w_sel_nxt   = '0;
        w_exg_nxt   = '0;
        w_wsel_nxt  = r_wsel;
        for (int unsigned b = 0; b < N_BG; b++) begin
            w_state_nxt[b] = r_state[b];
            w_ptr_nxt[b]   = r_ptr[b];
            w_cnt_nxt[b]   = r_cnt[b];
            w_own_nxt[b]   = r_own[b];
            case (r_state[b])
                S_IDLE: begin
                    if (ex_req[b]) begin
                        w_state_nxt[b] = S_EX;
                    end else begin
                        w_found = 1'b0;
                        for (int unsigned k = 0; k < N_LSU; k++) begin
                            w_idx = r_ptr[b] + 2'(k);
                            if (!w_found && lsu_req[w_idx] && (lsu_bg[2*w_idx +: 2] == 2'(b))) begin
                                w_found        = 1'b1;
                                w_state_nxt[b] = S_BURST;
                                w_own_nxt[b]   = w_idx;
                                w_cnt_nxt[b]   = lsu_len[LEN_W*w_idx +: LEN_W];
                                if (lsu_wr[w_idx]) begin
                                    w_wsel_nxt[2*w_idx +: 2] = 2'(b);
                                end
                            end
                        end
                    end
                end
                S_BURST: begin
                    // Abort and normal completion both hand the pointer past the owner.
                    if (!lsu_req[r_own[b]] || (lsu_bg[2*r_own[b] +: 2] != 2'(b)) || (r_cnt[b] == '0)) begin
                        w_state_nxt[b] = S_IDLE;
                        w_ptr_nxt[b]   = r_own[b] + 2'd1;
                    end else begin
                        w_cnt_nxt[b] = r_cnt[b] - 1'b1;
                    end
                end
                S_EX: begin
                    if (!ex_req[b]) begin
                        w_state_nxt[b] = S_IDLE;
                    end
                end
                default: w_state_nxt[b] = S_IDLE;
            endcase

            if (w_state_nxt[b] == S_BURST) begin
                w_gnt_nxt[w_own_nxt[b]] = 1'b1;
                if (w_cnt_nxt[b] == '0) begin
                    w_done_nxt[w_own_nxt[b]] = 1'b1;
                end
                w_sel_nxt[b]         = 1'b1;
                w_owner_nxt[2*b +: 2] = w_own_nxt[b];
            end
            w_busy_nxt[b] = (w_state_nxt[b] != S_IDLE);
            w_exg_nxt[b]  = (w_state_nxt[b] == S_EX);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int unsigned b = 0; b < N_BG; b++) begin
                r_state[b] <= S_IDLE;
                r_ptr[b]   <= '0;
                r_cnt[b]   <= '0;
                r_own[b]   <= '0;
            end
            r_gnt   <= '0;
            r_done  <= '0;
            r_wsel  <= '0;
            r_busy  <= '0;
            r_owner <= '0;
            r_sel   <= '0;
            r_exg   <= '0;
        end else begin
            for (int unsigned b = 0; b < N_BG; b++) begin
                r_state[b] <= w_state_nxt[b];
                r_ptr[b]   <= w_ptr_nxt[b];
                r_cnt[b]   <= w_cnt_nxt[b];
                r_own[b]   <= w_own_nxt[b];
            end
            r_gnt   <= w_gnt_nxt;
            r_done  <= w_done_nxt;
            r_wsel  <= w_wsel_nxt;
            r_busy  <= w_busy_nxt;
            r_owner <= w_owner_nxt;
            r_sel   <= w_sel_nxt;
            r_exg   <= w_exg_nxt;
        end
    end

    assign lsu_gnt   = r_gnt;
    assign lsu_done  = r_done;
    assign lsu_w_sel = r_wsel;
    assign bg_busy   = r_busy;
    assign bg_owner  = r_owner;
    assign bg_sel    = r_sel;
    assign ex_gnt    = r_exg;

endmodule

// File: doc/bg_access_arbiter.md
Name: bg_access_arbiter

Overview:
- Shares the four scratchpad bank groups (BG0..BG3) among the four LSUs and the external host bus.
- One round-robin arbiter with a burst counter per bank group.
- Grants, beat strobes and ownership are driven so the Host_Controller path can form the BGx_sel and LSU w_sel fields without hand-sequenced stimulus.
- Sits between LSU request logic and the SPM/crossbar configuration fields.

Parameters:
N_LSU, 4, number of requesting LSUs (fixed at 4 in this revision)
N_BG, 4, number of bank groups (fixed at 4)
LEN_W, 4, burst length field width; burst = len+1 beats, max 16

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous reset, active-low (0 = reset)
lsu_req  in  4  bit i: LSU i requests its target BG
lsu_bg  in  8  [2i+1:2i]: target BG of LSU i
lsu_wr  in  4  bit i: LSU i access is a write (FIFO/bank write)
lsu_len  in  16  [4i+3:4i]: beats-1 for LSU i burst
ex_req  in  4  bit b: external bus requests BG b
lsu_gnt  out  4  bit i: LSU i currently owns its target BG
lsu_done  out  4  bit i: one-cycle pulse on last beat of LSU i burst
lsu_w_sel  out  8  [2i+1:2i]: BG owned by LSU i when granted for write; holds last value otherwise
bg_busy  out  4  bit b: BG b owned (LSU or external)
bg_owner  out  8  [2b+1:2b]: index of LSU owning BG b; 0 when not LSU-owned
bg_sel  out  4  bit b: 1 = BG b routed to LSU crossbar, 0 = external bus (SPM BGx_sel)
ex_gnt  out  4  bit b: external bus owns BG b

Behaviour:
- Reset (rst=0 at a clock edge): all outputs 0, every BG FSM to IDLE, all RR pointers 0, counters 0. Applies mid-burst: ownership dropped immediately, no done pulse.
- Per-BG FSM states: IDLE, LSU_BURST, EX. All outputs registered.
- IDLE, evaluated each cycle:
  - ex_req[b]=1 -> EX next cycle; ex_gnt[b]=1, bg_busy[b]=1, bg_sel[b]=0.
  - Else the candidate set is LSUs i with lsu_req[i]=1 and lsu_bg[i]=b. Pick the first candidate at or after ptr[b], wrapping 3->0. Next cycle: LSU_BURST, lsu_gnt[i]=1, bg_owner[b]=i, bg_sel[b]=1, counter=lsu_len[i]; if lsu_wr[i], lsu_w_sel[i]=b.
  - No candidate -> stay IDLE.
- EX: hold while ex_req[b]=1. When it drops -> IDLE next cycle, ex_gnt[b]=0. No bound on EX duration; external always beats LSUs in IDLE, so starvation is permitted and software-managed.
- LSU_BURST:
  - Every cycle in the state is one beat; counter decrements per beat.
  - Beat with counter==0: lsu_done[i] pulses that cycle, state -> IDLE next cycle, ptr[b]=(i+1) mod 4.
  - A burst of len occupies exactly len+1 cycles of lsu_gnt.
- Latency: request at cycle t with BG idle -> lsu_gnt high t+1..t+1+len, done at t+1+len, gnt low t+2+len. At least one IDLE cycle always separates consecutive grants on the same BG.
- Abort: lsu_req[i] drops or lsu_bg[i] changes during LSU_BURST -> IDLE next cycle, no done pulse, ptr[b]=(i+1) mod 4.
- ex_req arriving during LSU_BURST waits for burst end or abort, then wins the following IDLE cycle.
- An LSU targets one BG, so it holds at most one grant; lsu_gnt[i] is the OR over BGs owned by i.
- lsu_len and lsu_wr are sampled only at grant. Changes mid-burst are ignored; lsu_bg changes abort as above.
- Different BGs arbitrate fully independently and in parallel in the same cycle.

Test Plan:
1. Reset release; LSU0 req, bg=1, len=3 -> lsu_gnt[0] high 4 cycles from t+1, bg_sel[1]=1, bg_owner[1]=0, lsu_done[0] on 4th beat, all back to 0 at t+5.
2. LSU0 and LSU2 both request BG0, len=1, held continuously -> grants alternate LSU0 (2 cycles), 1 idle, LSU2 (2 cycles), 1 idle, LSU0; ptr wraps correctly.
3. LSU i requests BG i for i=0..3, len=9, simultaneously -> all four lsu_gnt high the same 10 cycles; bg_owner=8'b11_10_01_00.
4. ex_req[2] raised during LSU1 burst on BG2 (len=5) -> burst completes with done; next IDLE cycle goes EX, ex_gnt[2]=1, bg_sel[2]=0; LSU3 request waits until ex_req[2] drops.
5. LSU1 write burst to BG3, lsu_req[1] dropped after 2 beats of len=7 -> gnt ends, no done pulse, lsu_w_sel[1]=3 retained, ptr[3]=2.
6. rst=0 asserted mid-burst of 16 beats -> next cycle all outputs 0; after release, same request regranted with a full 16 beats.
